change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Downstream of the vending machine controller: accepts the change amount it produces and drives three coin hoppers to pay it out, largest denomination first.
- Tracks per-hopper coin inventory and falls back to smaller coins when a hopper is empty.
- Reports the amount actually paid and any shortfall.
- Uses a one-hot eject/ack handshake per coin, with an enforced inter-coin gap.

Parameters:
- DEN0, 1, value of hopper 0 coin (smallest).
- DEN1, 5, value of hopper 1 coin.
- DEN2, 10, value of hopper 2 coin (largest).
- INIT_CNT, 8, coins loaded per hopper at reset and on refill, 0..255.
- GAP_CYC, 4, idle cycles between consecutive ejects, >=1.
- TMO_CYC, 64, ack timeout in cycles, only used with CHANGE_TMO_EN.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- i_change  input  5  change amount to pay, 0..31
- i_start  input  1  one-cycle request; i_change is sampled on this cycle
- i_refill  input  1  reloads all inventories to INIT_CNT; honoured only in IDLE
- i_ack  input  3  one-hot hopper acknowledge, coin physically released
- o_eject  output  3  one-hot eject request to hopper
- o_busy  output  1  high from the cycle after i_start until DONE is left
- o_done  output  1  one-cycle pulse at end of payout
- o_paid  output  5  running total paid in the current payout
- o_short  output  5  unpaid remainder, valid with o_done
- o_empty  output  3  per-hopper inventory == 0
- o_err  output  1  timeout flag, CHANGE_TMO_EN only, else tied 0

Behaviour:
- Reset (reset=0, async) values:
  - state IDLE; o_eject=0, o_busy=0, o_done=0, o_paid=0, o_short=0, o_err=0.
  - Inventories = INIT_CNT, so o_empty=0 unless INIT_CNT=0.
- Registers: rem (5b remaining), paid (5b), inv0..2 (8b), gap counter, timeout counter.
- IDLE:
  - i_start=1 -> rem<=i_change, paid<=0, go SELECT.
  - i_start with i_change=0 -> still goes SELECT, then DONE on the next cycle; o_short=0.
  - i_refill in IDLE -> inv<=INIT_CNT next cycle.
  - i_start and i_refill in the same cycle: refill applies, start applies; the payout uses the refilled counts.
- SELECT (1 cycle):
  - Pick the highest k with DEN_k<=rem and inv_k>0, then go EJECT with o_eject[k]=1.
  - If no k qualifies, or rem==0 -> DONE.
- EJECT:
  - o_eject held stable until the matching i_ack bit is high.
  - On ack: rem<=rem-DEN_k, paid<=paid+DEN_k, inv_k<=inv_k-1; o_eject drops next cycle; go GAP.
  - Non-matching i_ack bits are ignored.
- GAP:
  - Count GAP_CYC cycles with o_eject=0, then go SELECT.
- DONE (1 cycle):
  - o_done=1, o_short<=rem, o_busy=0 from the next cycle, go IDLE.
  - o_paid holds its value until the next i_start.
- i_start while busy: ignored.
- i_refill outside IDLE: ignored, not queued.
- Arithmetic:
  - rem never underflows, because selection requires DEN_k<=rem.
  - paid+DEN_k never exceeds the original i_change (<=31), so 5 bits suffice.
  - inv decrement only when inv>0; no wrap.
- Reset mid-payout: immediate return to IDLE with outputs at reset values and inventories reloaded to INIT_CNT.
- Latency: for a single coin, i_start to o_eject high = 2 cycles (SELECT registered).

Optional Feature:
- Macro CHANGE_TMO_EN.
- Defined:
  - A counter runs in EJECT. If no matching ack arrives within TMO_CYC cycles: o_err<=1 (sticky until reset or next i_start), o_eject drops, go DONE.
  - In that case o_short = rem, including the unacked coin; that hopper's inventory is not decremented.
- Undefined: no counter; EJECT waits indefinitely; o_err tied 0.

Test Plan:
- Basic greedy payout: INIT_CNT=8, i_change=17 -> ejects hopper2, then hopper1, then hopper0, hopper0 (acked one cycle after each eject) -> o_paid=17, o_short=0, o_done pulse, inv2=7, inv1=7, inv0=6.
- Empty fallback: drain hopper2 to 0 (o_empty[2]=1), i_change=10 -> two hopper1 ejects, paid=10, short=0.
- Shortfall: INIT_CNT=1, i_change=20 -> ejects 10,5,1 -> paid=16, short=4, all o_empty=1; refill in IDLE -> o_empty=000.
- Handshake and gap:
  - ack delayed 7 cycles -> o_eject stays stable for those cycles.
  - Wrong-hopper ack is ignored.
  - At least GAP_CYC zero cycles between ejects.
  - i_start during busy is ignored.
- Reset and zero change:
  - Assert reset mid-EJECT -> outputs 0 asynchronously, inventories back to INIT_CNT.
  - i_change=0 -> o_done 2 cycles after i_start, no eject.
- With CHANGE_TMO_EN, TMO_CYC=64: never ack hopper1 on i_change=5 -> o_err=1 after 64 cycles, o_short=5, inv1 unchanged.

Source files
------------

// File: rtl/change_dispenser.sv
// Three-hopper coin payout engine: pays a change amount largest coin first, tracking inventory per hopper.
// Optional macro CHANGE_TMO_EN adds an eject/ack timeout with a sticky o_err flag.
module change_dispenser #(
   parameter int DEN0     = 1,
   parameter int DEN1     = 5,
   parameter int DEN2     = 10,
   parameter int INIT_CNT = 8,
   parameter int GAP_CYC  = 4,
   parameter int TMO_CYC  = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] i_change,
   input  logic       i_start,
   input  logic       i_refill,
   input  logic [2:0] i_ack,
   output logic [2:0] o_eject,
   output logic       o_busy,
   output logic       o_done,
   output logic [4:0] o_paid,
   output logic [4:0] o_short,
   output logic [2:0] o_empty,
   output logic       o_err
);

   localparam logic [7:0] INIT_V = 8'(INIT_CNT);
   localparam int         GW     = $clog2(GAP_CYC + 1);

   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EJECT, S_GAP, S_DONE} state_t;

   state_t        state_q;
   logic [4:0]    rem_q, paid_q, short_q;
   logic [7:0]    inv_q [3];
   logic [1:0]    sel_q;
   logic [2:0]    eject_q;
   logic          busy_q, done_q;
   logic [GW-1:0] gap_q;
   logic [1:0]    sel_d;
   logic          sel_ok_d;

   function automatic logic [4:0] den_of(input logic [1:0] k);
      case (k)
         2'd0:    den_of = 5'(DEN0);
         2'd1:    den_of = 5'(DEN1);
         default: den_of = 5'(DEN2);
      endcase
   endfunction

   // Ascending scan, so the last qualifying hopper (largest coin) wins.
   always_comb begin
      sel_ok_d = 1'b0;
      sel_d    = 2'd0;
      for (int k = 0; k < 3; k++) begin
         if (rem_q != 5'd0 && den_of(2'(k)) <= rem_q && inv_q[k] != 8'd0) begin
            sel_ok_d = 1'b1;
            sel_d    = 2'(k);
         end
      end
   end

`ifdef CHANGE_TMO_EN
   localparam int TW = $clog2(TMO_CYC + 1);
   logic [TW-1:0] tmo_q;
   logic          err_q;
   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         paid_q  <= '0;
         short_q <= '0;
         sel_q   <= '0;
         eject_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gap_q   <= '0;
         for (int k = 0; k < 3; k++) inv_q[k] <= INIT_V;
`ifdef CHANGE_TMO_EN
         tmo_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_refill) begin
                  for (int k = 0; k < 3; k++) inv_q[k] <= INIT_V;
               end
               if (i_start) begin
                  rem_q   <= i_change;
                  paid_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_SELECT;
`ifdef CHANGE_TMO_EN
                  err_q   <= 1'b0;
`endif
               end
            end
            S_SELECT: begin
               if (sel_ok_d) begin
                  sel_q   <= sel_d;
                  eject_q <= 3'b001 << sel_d;
                  state_q <= S_EJECT;
`ifdef CHANGE_TMO_EN
                  tmo_q   <= '0;
`endif
               end else begin
                  done_q  <= 1'b1;
                  short_q <= rem_q;
                  state_q <= S_DONE;
               end
            end
            S_EJECT: begin
               if (i_ack[sel_q]) begin
                  rem_q        <= rem_q - den_of(sel_q);
                  paid_q       <= paid_q + den_of(sel_q);
                  inv_q[sel_q] <= inv_q[sel_q] - 8'd1;
                  eject_q      <= '0;
                  gap_q        <= '0;
                  state_q      <= S_GAP;
               end
`ifdef CHANGE_TMO_EN
               // Unacked coin stays in rem and in the inventory.
               else if (tmo_q == TW'(TMO_CYC - 1)) begin
                  err_q   <= 1'b1;
                  eject_q <= '0;
                  done_q  <= 1'b1;
                  short_q <= rem_q;
                  state_q <= S_DONE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
`endif
            end
            S_GAP: begin
               if (gap_q == GW'(GAP_CYC - 1)) state_q <= S_SELECT;
               else                           gap_q   <= gap_q + 1'b1;
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_empty
         assign o_empty[gi] = (inv_q[gi] == 8'd0);
      end
   endgenerate

   assign o_eject = eject_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_paid  = paid_q;
   assign o_short = short_q;

endmodule
